// File: rtl/rf_wb_arbiter.sv
// Register-file write-back controller.
// Round-robin arbitration between the ALU and LSU result streams for the
// single reg_file write port (A3/WD3/WE3, all registered), plus a
// per-register pending-write scoreboard that decode uses for RAW/WAW checks.
module rf_wb_arbiter #(
  parameter int WIDTH_REG = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  // decode issue / hazard query
  input  logic                 ISSUE_VALID,
  input  logic [4:0]           ISSUE_RD,
  output logic                 ISSUE_READY,
  input  logic [4:0]           Q_RS1,
  input  logic [4:0]           Q_RS2,
  output logic                 RAW_HAZARD,
  output logic [31:0]          BUSY,
  // ALU result stream
  input  logic                 ALU_VALID,
  input  logic [4:0]           ALU_RD,
  input  logic [WIDTH_REG-1:0] ALU_DATA,
  output logic                 ALU_READY,
  // LSU result stream
  input  logic                 LSU_VALID,
  input  logic [4:0]           LSU_RD,
  input  logic [WIDTH_REG-1:0] LSU_DATA,
  output logic                 LSU_READY,
  // reg_file write port
  output logic [4:0]           A3,
  output logic [WIDTH_REG-1:0] WD3,
  output logic                 WE3
);

  // Round-robin pointer: 0 = ALU has priority, 1 = LSU has priority.
  logic                 r_ptr;
  logic [31:0]          r_busy;
  logic [4:0]           r_a3;
  logic [WIDTH_REG-1:0] r_wd3;
  logic                 r_we3;

  logic                 w_gnt_alu;
  logic                 w_gnt_lsu;
  logic                 w_both;
  logic                 w_issue_fire;
  logic [31:0]          w_set_mask;
  logic [31:0]          w_clr_mask;
  logic [31:0]          w_busy_nxt;
  logic [4:0]           w_win_rd;
  logic [WIDTH_REG-1:0] w_win_data;

  // Grant decision: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    w_both    = ALU_VALID & LSU_VALID;
    w_gnt_alu = 1'b0;
    w_gnt_lsu = 1'b0;
    if (w_both) begin
      w_gnt_alu = ~r_ptr;
      w_gnt_lsu = r_ptr;
    end else begin
      w_gnt_alu = ALU_VALID;
      w_gnt_lsu = LSU_VALID;
    end
  end

  // Winner's payload, selected for the output register stage.
  always_comb begin
    w_win_rd   = 5'd0;
    w_win_data = '0;
    if (w_gnt_lsu) begin
      w_win_rd   = LSU_RD;
      w_win_data = LSU_DATA;
    end else begin
      w_win_rd   = ALU_RD;
      w_win_data = ALU_DATA;
    end
  end

  // Scoreboard next state: commit clears A3, an accepted issue sets its rd.
  // The set mask is OR-ed after the clear so a same-edge set/clear keeps the
  // bit high; bit 0 is forced low because x0 never has a pending write.
  always_comb begin
    w_issue_fire = ISSUE_VALID & ~r_busy[ISSUE_RD];
    w_set_mask   = (w_issue_fire && (ISSUE_RD != 5'd0)) ? (32'd1 << ISSUE_RD) : 32'd0;
    w_clr_mask   = r_we3 ? (32'd1 << r_a3) : 32'd0;
    w_busy_nxt   = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
  end

  // Pointer update: only a contested grant hands priority to the loser.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr <= 1'b0;
    end else if (w_both) begin
      r_ptr <= ~r_ptr;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Write-port register stage; A3/WD3 hold when nothing is granted, and an
  // x0 result is accepted without raising WE3.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a3  <= 5'd0;
      r_wd3 <= '0;
      r_we3 <= 1'b0;
    end else if (w_gnt_alu || w_gnt_lsu) begin
      r_a3  <= w_win_rd;
      r_wd3 <= w_win_data;
      r_we3 <= (w_win_rd != 5'd0);
    end else begin
      r_a3  <= r_a3;
      r_wd3 <= r_wd3;
      r_we3 <= 1'b0;
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign ALU_READY   = w_gnt_alu;
  assign LSU_READY   = w_gnt_lsu;
  assign ISSUE_READY = ~r_busy[ISSUE_RD];
  assign RAW_HAZARD  = r_busy[Q_RS1] | r_busy[Q_RS2];
  assign BUSY        = r_busy;
  assign A3          = r_a3;
  assign WD3         = r_wd3;
  assign WE3         = r_we3;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a reference model predicts grants,
// scoreboard bits and the registered write port; predicted write-port values
// are queued when stimulus is applied and compared the following cycle.
module tb_rf_wb_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        ISSUE_VALID;
  logic [4:0]  ISSUE_RD;
  logic        ISSUE_READY;
  logic [4:0]  Q_RS1;
  logic [4:0]  Q_RS2;
  logic        RAW_HAZARD;
  logic [31:0] BUSY;
  logic        ALU_VALID;
  logic [4:0]  ALU_RD;
  logic [31:0] ALU_DATA;
  logic        ALU_READY;
  logic        LSU_VALID;
  logic [4:0]  LSU_RD;
  logic [31:0] LSU_DATA;
  logic        LSU_READY;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        WE3;

  rf_wb_arbiter #(.WIDTH_REG(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .ISSUE_READY(ISSUE_READY),
    .Q_RS1(Q_RS1), .Q_RS2(Q_RS2), .RAW_HAZARD(RAW_HAZARD), .BUSY(BUSY),
    .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .LSU_VALID(LSU_VALID), .LSU_RD(LSU_RD), .LSU_DATA(LSU_DATA), .LSU_READY(LSU_READY),
    .A3(A3), .WD3(WD3), .WE3(WE3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
  } wb_t;

  wb_t         exp_q[$];
  wb_t         cur;
  logic [31:0] m_busy;
  logic        m_ptr;
  logic        last_g_alu;
  logic        last_g_lsu;
  int          n_total;
  int          n_bad;

  // Single comparison point: counts and reports any difference.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ISSUE_VALID = 1'b0; ISSUE_RD = 5'd0;
    ALU_VALID = 1'b0; ALU_RD = 5'd0; ALU_DATA = 32'd0;
    LSU_VALID = 1'b0; LSU_RD = 5'd0; LSU_DATA = 32'd0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur    = '0;
    m_busy = 32'd0;
    m_ptr  = 1'b0;
  endtask

  // One clock cycle: check DUT against the model mid-cycle, advance the model,
  // queue the expected write port for the next cycle, then cross the edge.
  task automatic cyc();
    wb_t         nxt;
    logic        g_alu;
    logic        g_lsu;
    logic        iss;
    logic [31:0] nb;
    @(negedge CLK);
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    g_alu = ALU_VALID && (!LSU_VALID || !m_ptr);
    g_lsu = LSU_VALID && (!ALU_VALID || m_ptr);
    iss   = ISSUE_VALID && !m_busy[ISSUE_RD];
    check("we3", {31'd0, WE3}, {31'd0, cur.we});
    check("a3", {27'd0, A3}, {27'd0, cur.a3});
    check("wd3", WD3, cur.wd);
    check("busy", BUSY, m_busy);
    check("issue_ready", {31'd0, ISSUE_READY}, {31'd0, !m_busy[ISSUE_RD]});
    check("raw_hazard", {31'd0, RAW_HAZARD}, {31'd0, (m_busy[Q_RS1] | m_busy[Q_RS2])});
    check("alu_ready", {31'd0, ALU_READY}, {31'd0, g_alu});
    check("lsu_ready", {31'd0, LSU_READY}, {31'd0, g_lsu});
    nb = m_busy;
    if (cur.we) nb[cur.a3] = 1'b0;
    if (iss && (ISSUE_RD != 5'd0)) nb[ISSUE_RD] = 1'b1;
    m_busy = nb;
    if (ALU_VALID && LSU_VALID) m_ptr = !m_ptr;
    if (g_alu) begin
      nxt.we = (ALU_RD != 5'd0); nxt.a3 = ALU_RD; nxt.wd = ALU_DATA;
    end else if (g_lsu) begin
      nxt.we = (LSU_RD != 5'd0); nxt.a3 = LSU_RD; nxt.wd = LSU_DATA;
    end else begin
      nxt.we = 1'b0; nxt.a3 = cur.a3; nxt.wd = cur.wd;
    end
    exp_q.push_back(nxt);
    last_g_alu = g_alu;
    last_g_lsu = g_lsu;
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    ISSUE_VALID = 1'b1; ISSUE_RD = rd;
    cyc();
    idle();
  endtask

  logic [4:0] alu_rds[4];
  logic [4:0] lsu_rds[4];
  logic [3:0] order;
  int         ai;
  int         li;
  int         ng;

  initial begin
    n_total = 0;
    n_bad   = 0;
    idle();
    Q_RS1 = 5'd0; Q_RS2 = 5'd0;
    model_reset();
    RST_N = 1'b0;
    #12;
    // reset state
    check("rst_busy", BUSY, 32'd0);
    check("rst_we3", {31'd0, WE3}, 32'd0);
    check("rst_a3", {27'd0, A3}, 32'd0);
    check("rst_wd3", WD3, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // single ALU write-back: issue rd=5, result two cycles later
    issue(5'd5);
    cyc();
    ALU_VALID = 1'b1; ALU_RD = 5'd5; ALU_DATA = 32'hDEADBEEF;
    cyc();
    idle();
    cyc();                // commit cycle: WE3=1, A3=5
    cyc();                // BUSY[5] now clear
    check("busy5_clear", {31'd0, BUSY[5]}, 32'd0);

    // contention: issue rd 1..8, then both streams valid
    for (int r = 1; r <= 8; r++) issue(5'(r));
    for (int i = 0; i < 4; i++) begin
      alu_rds[i] = 5'(2 * i + 1);
      lsu_rds[i] = 5'(2 * i + 2);
    end
    ai = 0; li = 0; ng = 0; order = 4'd0;
    for (int k = 0; k < 20 && (ai < 4 || li < 4); k++) begin
      ALU_VALID = (ai < 4);
      ALU_RD    = (ai < 4) ? alu_rds[ai] : 5'd0;
      ALU_DATA  = 32'hA000_0000 | {27'd0, ALU_RD};
      LSU_VALID = (li < 4);
      LSU_RD    = (li < 4) ? lsu_rds[li] : 5'd0;
      LSU_DATA  = 32'hB000_0000 | {27'd0, LSU_RD};
      cyc();
      if (ng < 4) begin
        order[3 - ng] = last_g_alu;
        ng++;
      end
      if (last_g_alu) ai++;
      if (last_g_lsu) li++;
    end
    idle();
    check("contention_drained", 32'(ai + li), 32'd8);
    check("rr_order", {28'd0, order}, 32'b1010);
    cyc();
    cyc();
    check("busy_after_contention", BUSY, 32'd0);

    // x0 write: accepted, no write enable, scoreboard untouched
    LSU_VALID = 1'b1; LSU_RD = 5'd0; LSU_DATA = 32'h1234;
    cyc();
    idle();
    cyc();
    cyc();

    // hazards on rd=7: RAW while pending, WAW stall until the bit clears
    issue(5'd7);
    Q_RS1 = 5'd7; Q_RS2 = 5'd0;
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd7;
    cyc();
    cyc();
    check("raw7_pending", {31'd0, RAW_HAZARD}, 32'd1);
    ALU_VALID = 1'b1; ALU_RD = 5'd7; ALU_DATA = 32'h0000_0777;
    cyc();
    ALU_VALID = 1'b0;
    cyc();                // commit cycle, bit still set
    cyc();                // bit clear: second issue of rd=7 accepted
    ISSUE_VALID = 1'b0;
    cyc();
    check("busy7_reissued", {31'd0, BUSY[7]}, 32'd1);
    Q_RS1 = 5'd0;

    // set/clear collision on rd=9 (write-back of a non-busy register)
    ALU_VALID = 1'b1; ALU_RD = 5'd9; ALU_DATA = 32'h9999_0009;
    cyc();
    idle();
    ISSUE_VALID = 1'b1; ISSUE_RD = 5'd9;
    cyc();                // commit of 9 and issue of 9 on the same edge
    idle();
    cyc();
    check("busy9_collision", {31'd0, BUSY[9]}, 32'd1);

    // asynchronous reset mid-cycle with a write in flight
    issue(5'd3);
    issue(5'd10);
    issue(5'd11);
    ALU_VALID = 1'b1; ALU_RD = 5'd3; ALU_DATA = 32'h3333_3333;
    cyc();
    idle();
    check("inflight_we3", {31'd0, WE3}, 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_busy", BUSY, 32'd0);
    check("arst_we3", {31'd0, WE3}, 32'd0);
    check("arst_a3", {27'd0, A3}, 32'd0);
    check("arst_wd3", WD3, 32'd0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    for (int r = 0; r < 32; r++) begin
      ISSUE_RD = 5'(r);
      #1;
      check("ready_after_rst", {31'd0, ISSUE_READY}, 32'd1);
    end
    ISSUE_RD = 5'd0;
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
